// File: rtl/overture_pkg.sv
// Shared types and constants for the overture 8-bit accumulator-style core.
package overture_pkg;

  // Top two instruction bits select the instruction class.
  typedef enum logic [1:0] {
    OP_IMM  = 2'b00,
    OP_CALC = 2'b01,
    OP_COPY = 2'b10,
    OP_COND = 2'b11
  } opcode_e;

  // CALC function in ir[2:0]; r3 = f(r1, r2).
  typedef enum logic [2:0] {
    ALU_OR   = 3'd0,
    ALU_NAND = 3'd1,
    ALU_NOR  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_ADD  = 3'd4,
    ALU_SUB  = 3'd5,
    ALU_RSV6 = 3'd6,
    ALU_RSV7 = 3'd7
  } alu_op_e;

  // COND test in ir[2:0], applied to r3 as a signed value.
  typedef enum logic [2:0] {
    CC_NEVER  = 3'd0,
    CC_EQZ    = 3'd1,
    CC_LTZ    = 3'd2,
    CC_LEZ    = 3'd3,
    CC_ALWAYS = 3'd4,
    CC_NEZ    = 3'd5,
    CC_GEZ    = 3'd6,
    CC_GTZ    = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_WAIT_IN  = 2'd2,
    ST_WAIT_OUT = 2'd3
  } state_e;

  // Register index 6 is the I/O port; index 7 reads zero and drops writes.
  localparam logic [2:0] IO_REG = 3'd6;

endpackage

// File: rtl/overture_alu.sv
// Combinational CALC result and COND decision.
module overture_alu
  import overture_pkg::*;
(
  input  logic [7:0] i_r1,
  input  logic [7:0] i_r2,
  input  logic [7:0] i_r3,
  input  logic [2:0] i_func,
  output logic [7:0] o_calc,
  output logic       o_take
);

  logic w_zero;
  logic w_neg;

  assign w_zero = (i_r3 == 8'h00);
  assign w_neg  = i_r3[7];

  // Logic/arithmetic result; modulo 256, no carry kept.
  always_comb begin
    o_calc = 8'h00;
    unique case (alu_op_e'(i_func))
      ALU_OR:   o_calc = i_r1 | i_r2;
      ALU_NAND: o_calc = ~(i_r1 & i_r2);
      ALU_NOR:  o_calc = ~(i_r1 | i_r2);
      ALU_AND:  o_calc = i_r1 & i_r2;
      ALU_ADD:  o_calc = i_r1 + i_r2;
      ALU_SUB:  o_calc = i_r1 - i_r2;
      ALU_RSV6: o_calc = 8'h00;
      ALU_RSV7: o_calc = 8'h00;
    endcase
  end

  // Branch decision from sign/zero of r3.
  always_comb begin
    o_take = 1'b0;
    unique case (cond_e'(i_func))
      CC_NEVER:  o_take = 1'b0;
      CC_EQZ:    o_take = w_zero;
      CC_LTZ:    o_take = w_neg;
      CC_LEZ:    o_take = w_neg | w_zero;
      CC_ALWAYS: o_take = 1'b1;
      CC_NEZ:    o_take = ~w_zero;
      CC_GEZ:    o_take = ~w_neg;
      CC_GTZ:    o_take = ~w_neg & ~w_zero;
    endcase
  end

endmodule

// File: rtl/overture_cpu.sv
// Overture core: 2-cycle fetch/execute with blocking I/O port handshakes.
module overture_cpu
  import overture_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [7:0]      r_pc;
  logic [7:0]      r_ir;
  logic [5:0][7:0] r_gpr;
  logic [7:0]      r_out_data;
  logic            r_out_valid;
  logic            r_in_ready;
  state_e          r_state;

  opcode_e    w_op;
  logic [2:0] w_src;
  logic [2:0] w_dst;
  logic [7:0] w_src_val;
  logic [7:0] w_pc_inc;
  logic [7:0] w_alu_res;
  logic       w_take;

  assign w_op     = opcode_e'(r_ir[7:6]);
  assign w_src    = r_ir[5:3];
  assign w_dst    = r_ir[2:0];
  assign w_pc_inc = r_pc + 8'd1;

  assign rom_address = r_pc;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign in_ready    = r_in_ready;

  overture_alu u_alu (
    .i_r1   (r_gpr[1]),
    .i_r2   (r_gpr[2]),
    .i_r3   (r_gpr[3]),
    .i_func (r_ir[2:0]),
    .o_calc (w_alu_res),
    .o_take (w_take)
  );

  // COPY source read for register-file sources; index 7 (and 6, never used here) give zero.
  always_comb begin
    w_src_val = 8'h00;
    if (w_src < IO_REG) w_src_val = r_gpr[w_src];
  end

  // Main sequencer: fetch, execute, and the two port-wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= 8'h00;
      r_gpr       <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_state     <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= rom_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (w_op)
            OP_IMM: begin
              r_gpr[0] <= {2'b00, r_ir[5:0]};
              r_pc     <= w_pc_inc;
            end
            OP_CALC: begin
              r_gpr[3] <= w_alu_res;
              r_pc     <= w_pc_inc;
            end
            OP_COND: begin
              r_pc <= w_take ? r_gpr[0] : w_pc_inc;
            end
            OP_COPY: begin
              if (w_src == IO_REG) begin
                r_in_ready <= 1'b1;
                r_state    <= ST_WAIT_IN;
              end else if (w_dst == IO_REG) begin
                r_out_data  <= w_src_val;
                r_out_valid <= 1'b1;
                r_state     <= ST_WAIT_OUT;
              end else begin
                if (w_dst < IO_REG) r_gpr[w_dst] <= w_src_val;
                r_pc <= w_pc_inc;
              end
            end
            default: r_pc <= w_pc_inc;
          endcase
        end
        ST_WAIT_IN: begin
          // Input accepted only here; port-to-port copies continue to the output wait.
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (w_dst == IO_REG) begin
              r_out_data  <= in_data;
              r_out_valid <= 1'b1;
              r_state     <= ST_WAIT_OUT;
            end else begin
              if (w_dst < IO_REG) r_gpr[w_dst] <= in_data;
              r_pc    <= w_pc_inc;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_WAIT_OUT: begin
          // out_data stays put after the handshake; only valid drops.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_pc_inc;
            r_state     <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_overture_cpu.sv
// Directed bench for overture_cpu: ROM model, output scoreboard, PC/handshake checks.
module tb_overture_cpu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] rom [256];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  overture_cpu #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_address];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input int f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      0: return a | b;
      1: return ~(a & b);
      2: return ~(a | b);
      3: return a & b;
      4: return a + b;
      5: return a - b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset is released 1 time unit after an edge, so the next edge is the first fetch.
  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: every completed output handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_output", 8'(exp_q.size()), 8'd1);
      else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;

    // Countdown loop: r3 becomes 0, COND ==0 jumps back to 0.
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h81; rom[3] = 8'h0A;
    rom[4] = 8'h82; rom[5] = 8'h44; rom[6] = 8'h99; rom[7] = 8'h0F;
    rom[8] = 8'h82; rom[9] = 8'h45; rom[10] = 8'h00; rom[11] = 8'hC1;
    #2;
    chk("reset_pc", rom_address, 8'h00);
    chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_in_ready", {7'd0, in_ready}, 8'd0);
    chk("reset_out_data", out_data, 8'h00);
    reset_dut();
    step(2);  chk("loop_pc1", rom_address, 8'h01);
    step(20); chk("loop_pc11", rom_address, 8'h0B);
    step(2);  chk("loop_jump0", rom_address, 8'h00);
    step(24); chk("loop_repeat", rom_address, 8'h00);

    // Output stall: out_data held while out_ready low.
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'h86;
    reset_dut();
    exp_q.push_back(8'h3F);
    step(4);
    chk("stall_valid", {7'd0, out_valid}, 8'd1);
    chk("stall_data", out_data, 8'h3F);
    chk("stall_pc", rom_address, 8'h01);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_hold_valid", {7'd0, out_valid}, 8'd1);
      chk("stall_hold_data", out_data, 8'h3F);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("stall_done_valid", {7'd0, out_valid}, 8'd0);
    chk("stall_done_pc", rom_address, 8'h02);
    chk("stall_data_retained", out_data, 8'h3F);

    // Late input: early in_valid ignored, A5 captured in WAIT_IN, echoed to output.
    clear_rom();
    rom[0] = 8'hB1; rom[1] = 8'h8E;
    reset_dut();
    in_valid = 1'b1;
    in_data = 8'h5A;
    chk("in_ready_fetch", {7'd0, in_ready}, 8'd0);
    step(1);
    chk("in_ready_exec", {7'd0, in_ready}, 8'd0);
    step(1);
    in_valid = 1'b0;
    chk("in_ready_wait", {7'd0, in_ready}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("in_ready_hold", {7'd0, in_ready}, 8'd1);
    end
    in_data = 8'hA5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    step(1);
    in_valid = 1'b0;
    chk("in_ready_after", {7'd0, in_ready}, 8'd0);
    chk("in_capture_pc", rom_address, 8'h01);
    step(3);
    chk("in_echo_pc", rom_address, 8'h02);

    // 80-01 = 7F: <0 falls through, >0 jumps to r0 = 1A.
    clear_rom();
    rom[0] = 8'hB1; rom[1] = 8'h01; rom[2] = 8'h82; rom[3] = 8'h45;
    rom[4] = 8'h1A; rom[5] = 8'hC2; rom[6] = 8'hC7; rom[7] = 8'h9E;
    rom[8'h1A] = 8'h9E;
    reset_dut();
    in_data = 8'h80;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'h7F);
    step(3);
    in_valid = 1'b0;
    chk("sub_in_pc", rom_address, 8'h01);
    step(10); chk("cond_lt_nojump", rom_address, 8'h06);
    step(2);  chk("cond_gt_jump", rom_address, 8'h1A);
    step(3);  chk("sub_out_pc", rom_address, 8'h1B);

    // ALU sweep: r1 = 3C, r2 = 0A, all eight functions copied to the port.
    clear_rom();
    rom[0] = 8'h3C; rom[1] = 8'h81; rom[2] = 8'h0A; rom[3] = 8'h82;
    for (int k = 0; k < 8; k++) begin
      rom[4 + 2 * k] = 8'(8'h40 | k);
      rom[5 + 2 * k] = 8'h9E;
    end
    reset_dut();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(alu_ref(k, 8'h3C, 8'h0A));
    step(48);
    chk("alu_sweep_pc", rom_address, 8'h14);

    // PC wrap: jump to FF via input-loaded r0, then FF increments to 00.
    clear_rom();
    rom[0] = 8'hB0; rom[1] = 8'hC4; rom[255] = 8'h01;
    reset_dut();
    in_data = 8'hFF;
    in_valid = 1'b1;
    step(3);
    in_valid = 1'b0;
    chk("wrap_in_pc", rom_address, 8'h01);
    step(2); chk("wrap_at_ff", rom_address, 8'hFF);
    step(2); chk("wrap_to_00", rom_address, 8'h00);

    // Asynchronous reset in the middle of an output handshake.
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'h86;
    reset_dut();
    step(4);
    chk("pre_rst_valid", {7'd0, out_valid}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("async_rst_pc", rom_address, 8'h00);
    chk("async_rst_data", out_data, 8'h00);
    chk("async_rst_in_ready", {7'd0, in_ready}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2); chk("first_fetch_pc", rom_address, 8'h01);
    step(2);
    chk("rerun_valid", {7'd0, out_valid}, 8'd1);
    chk("rerun_data", out_data, 8'h3F);

    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
